instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Serial instruction loader: receives an 'L'-framed word image over a byte stream,
// writes it into instruction memory and answers with 'K' (good) or 'E' (error).
module instr_loader #(
   parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [7:0]  out_data_i,
   input  logic        out_valid_i,
   output logic        out_ready_o,
   output logic [7:0]  in_data_o,
   output logic        in_valid_o,
   input  logic        in_ready_i,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CNT_LO = 3'd1;
   localparam logic [2:0] S_CNT_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CSUM   = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   localparam logic [7:0]  CH_L     = 8'h4C;
   localparam logic [7:0]  CH_K     = 8'h4B;
   localparam logic [7:0]  CH_E     = 8'h45;
   localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 1;

   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] idx_q, idx_d;
   logic [1:0]  bidx_q, bidx_d;
   logic [31:0] asm_q, asm_d;
   logic [7:0]  csum_q, csum_d;
   logic [31:0] tmo_q, tmo_d;
   logic [7:0]  resp_q, resp_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        done_q, done_d;

   logic        accept;
   logic        counting;
   logic [15:0] n_words;
   logic [31:0] word_nxt;

   assign out_ready_o = (state_q != S_RESP);
   assign in_valid_o  = (state_q == S_RESP);
   assign in_data_o   = in_valid_o ? resp_q : 8'h00;
   assign busy_o      = (state_q != S_IDLE);
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign done_o      = done_q;

   assign accept   = out_valid_i && out_ready_o;
   assign counting = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
   assign n_words  = {out_data_i, cnt_q[7:0]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      bidx_d   = bidx_q;
      asm_d    = asm_q;
      csum_d   = csum_q;
      tmo_d    = tmo_q;
      resp_d   = resp_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      done_d   = 1'b0;
      word_nxt = asm_q;
      word_nxt[{bidx_q, 3'b000} +: 8] = out_data_i;

      if (counting) tmo_d = tmo_q + 32'd1;
      if (accept)   tmo_d = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (accept && out_data_i == CH_L) begin
               state_d = S_CNT_LO;
               tmo_d   = 32'd0;
            end
         end
         S_CNT_LO: begin
            if (accept) begin
               cnt_d   = {8'h00, out_data_i};
               state_d = S_CNT_HI;
            end
         end
         S_CNT_HI: begin
            if (accept) begin
               cnt_d = n_words;
               if (n_words == 16'd0 || {16'd0, n_words} > MAX_WORDS) begin
                  state_d = S_RESP;
                  resp_d  = CH_E;
               end else begin
                  state_d = S_DATA;
                  idx_d   = 16'd0;
                  bidx_d  = 2'd0;
                  csum_d  = 8'd0;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_d = csum_q + out_data_i;
               asm_d  = word_nxt;
               bidx_d = bidx_q + 2'd1;
               // A full word is registered and strobed on the following cycle.
               if (bidx_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = MEM_BASE + {14'd0, idx_q, 2'b00};
                  wdata_d = word_nxt;
                  idx_d   = idx_q + 16'd1;
                  if (idx_q == cnt_q - 16'd1) state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               state_d = S_RESP;
               resp_d  = (out_data_i == csum_q) ? CH_K : CH_E;
            end
         end
         S_RESP: begin
            if (in_ready_i) begin
               state_d = S_IDLE;
               done_d  = (resp_q == CH_K);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // An accepted byte always beats an expiring timeout.
      if (counting && !accept && tmo_q == TMO_LAST) begin
         state_d = S_RESP;
         resp_d  = CH_E;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         idx_q   <= 16'd0;
         bidx_q  <= 2'd0;
         asm_q   <= 32'd0;
         csum_q  <= 8'd0;
         tmo_q   <= 32'd0;
         resp_q  <= 8'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         bidx_q  <= bidx_d;
         asm_q   <= asm_d;
         csum_q  <= csum_d;
         tmo_q   <= tmo_d;
         resp_q  <= resp_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
      end
   end

endmodule
